// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch front end: sequential fetch, one outstanding request,
// small FIFO toward decode, flush-and-refetch on branch/jump redirect.
module fetch_prefetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_rvalid,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [INSTR_W-1:0]         instruction,
    output logic [ADDR_W-1:0]          PC_out,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic push;
    logic pop;

    assign imem_req  = (state_q == S_IDLE) && (count_q < CW'(DEPTH))
                       && !redirect && !reset;
    assign imem_addr = fetch_pc_q;
    assign valid     = (count_q != '0) && !reset;
    assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop       = valid && !stall && !redirect;

    assign instruction = valid ? instr_mem_q[rd_ptr_q] : '0;
    assign PC_out      = valid ? pc_mem_q[rd_ptr_q] : '0;
    assign occupancy   = reset ? '0 : count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: if (imem_req) state_d = S_WAIT;
            S_WAIT: begin
                if (redirect) state_d = imem_rvalid ? S_IDLE : S_DROP;
                else if (imem_rvalid) state_d = S_IDLE;
            end
            S_DROP: if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (imem_req) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Redirect wins over everything: drop the queue, restart at target.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a behavioural instruction
// memory that answers 16'hA000+addr after a programmable latency.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] instruction;
    logic [7:0]  PC_out;
    logic        valid;
    logic [2:0]  occupancy;

    int nvec = 0;
    int nerr = 0;

    int          lat = 1;
    logic        pend = 1'b0;
    int          left = 0;
    logic [7:0]  paddr = '0;
    logic        mem_rv = 1'b0;
    logic [15:0] mem_rd = '0;
    logic        stray = 1'b0;
    logic        req_s, rst_s;
    logic [7:0]  addr_s;

    always #5 clk = ~clk;

    fetch_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .PC_out      (PC_out),
        .valid       (valid),
        .occupancy   (occupancy)
    );

    assign imem_rvalid = mem_rv | stray;
    assign imem_rdata  = stray ? 16'hBEEF : mem_rd;

    // Memory model: forgets any in-flight request across reset.
    always @(posedge clk) begin
        req_s  = imem_req;
        addr_s = imem_addr;
        rst_s  = reset;
        #1;
        mem_rv = 1'b0;
        if (rst_s) begin
            pend = 1'b0;
        end else begin
            if (req_s) begin
                pend  = 1'b1;
                paddr = addr_s;
                left  = lat;
            end
            if (pend) begin
                left = left - 1;
                if (left == 0) begin
                    mem_rv = 1'b1;
                    mem_rd = 16'hA000 + {8'h00, paddr};
                    pend   = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        cyc(); cyc(); #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_instr", 32'(instruction), 0);
        chk("rst_pc", 32'(PC_out), 0);

        // Test 1: sequential fetch, 1-cycle memory, no stall
        cyc(); reset = 1'b0; #1;
        chk("t1_c0_req", 32'(imem_req), 1);
        chk("t1_c0_addr", 32'(imem_addr), 'h00);
        chk("t1_c0_valid", 32'(valid), 0);
        cyc(); #1;
        chk("t1_c1_req", 32'(imem_req), 0);
        chk("t1_c1_valid", 32'(valid), 0);
        cyc(); #1;
        chk("t1_c2_valid", 32'(valid), 1);
        chk("t1_c2_pc", 32'(PC_out), 'h00);
        chk("t1_c2_instr", 32'(instruction), 'hA000);
        chk("t1_c2_req", 32'(imem_req), 1);
        chk("t1_c2_addr", 32'(imem_addr), 'h01);
        chk("t1_c2_occ", 32'(occupancy), 1);
        cyc(); #1;
        chk("t1_c3_valid", 32'(valid), 0);
        cyc(); #1;
        chk("t1_c4_valid", 32'(valid), 1);
        chk("t1_c4_pc", 32'(PC_out), 'h01);
        chk("t1_c4_instr", 32'(instruction), 'hA001);
        chk("t1_c4_addr", 32'(imem_addr), 'h02);

        // Outputs are forced idle while reset is held, even with data queued
        reset = 1'b1;
        stall = 1'b1;
        #1;
        chk("rst2_valid", 32'(valid), 0);
        chk("rst2_occ", 32'(occupancy), 0);
        chk("rst2_req", 32'(imem_req), 0);

        // Test 2: stall from reset fills the queue with 0x00..0x03
        cyc(); reset = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        #1;
        chk("t2_full_occ", 32'(occupancy), 4);
        chk("t2_full_req", 32'(imem_req), 0);
        chk("t2_full_pc", 32'(PC_out), 'h00);
        chk("t2_full_instr", 32'(instruction), 'hA000);
        cyc(); stall = 1'b0; #1;
        chk("t2_pop_occ", 32'(occupancy), 4);
        chk("t2_pop_req", 32'(imem_req), 0);
        cyc(); stall = 1'b1; #1;
        chk("t2_after_occ", 32'(occupancy), 3);
        chk("t2_after_pc", 32'(PC_out), 'h01);
        chk("t2_after_req", 32'(imem_req), 1);
        chk("t2_after_addr", 32'(imem_addr), 'h04);
        cyc();
        cyc(); #1;
        chk("t2_refill_occ", 32'(occupancy), 4);
        chk("t2_refill_req", 32'(imem_req), 0);

        // Test 3: redirect while a slow request is in flight
        stall = 1'b0;
        lat   = 3;
        cyc(); stall = 1'b1; #1;
        chk("t3_req", 32'(imem_req), 1);
        chk("t3_addr", 32'(imem_addr), 'h05);
        chk("t3_occ", 32'(occupancy), 3);
        cyc(); redirect = 1'b1; redirect_pc = 8'h40; #1;
        chk("t3_redir_req", 32'(imem_req), 0);
        cyc(); redirect = 1'b0; #1;
        chk("t3_flush_valid", 32'(valid), 0);
        chk("t3_flush_occ", 32'(occupancy), 0);
        chk("t3_drop_req", 32'(imem_req), 0);
        chk("t3_drop_addr", 32'(imem_addr), 'h40);
        cyc(); #1;
        chk("t3_stale_req", 32'(imem_req), 0);
        chk("t3_stale_valid", 32'(valid), 0);
        cyc(); lat = 1; #1;
        chk("t3_tgt_req", 32'(imem_req), 1);
        chk("t3_tgt_addr", 32'(imem_addr), 'h40);
        chk("t3_tgt_occ", 32'(occupancy), 0);
        cyc();
        cyc(); #1;
        chk("t3_tgt_valid", 32'(valid), 1);
        chk("t3_tgt_pc", 32'(PC_out), 'h40);
        chk("t3_tgt_instr", 32'(instruction), 'hA040);

        // Test 4: redirect coincides with a response and an unstalled head
        cyc();
        cyc(); #1;
        chk("t4_pre_occ", 32'(occupancy), 2);
        cyc(); redirect = 1'b1; stall = 1'b0; redirect_pc = 8'hFE; #1;
        chk("t4_redir_valid", 32'(valid), 1);
        chk("t4_redir_req", 32'(imem_req), 0);
        cyc(); redirect = 1'b0; #1;
        chk("t4_occ", 32'(occupancy), 0);
        chk("t4_valid", 32'(valid), 0);
        chk("t4_req", 32'(imem_req), 1);
        chk("t4_addr", 32'(imem_addr), 'hFE);

        // Test 5: PC wraps from 0xFF to 0x00
        cyc();
        cyc(); #1;
        chk("t5_fe_pc", 32'(PC_out), 'hFE);
        chk("t5_fe_instr", 32'(instruction), 'hA0FE);
        cyc();
        cyc(); #1;
        chk("t5_ff_pc", 32'(PC_out), 'hFF);
        chk("t5_wrap_addr", 32'(imem_addr), 'h00);
        cyc();
        cyc(); #1;
        chk("t5_00_pc", 32'(PC_out), 'h00);
        chk("t5_00_instr", 32'(instruction), 'hA000);
        chk("t5_next_addr", 32'(imem_addr), 'h01);

        // Test 6: reset in WAIT, stray response afterwards is ignored
        lat = 3;
        cyc(); reset = 1'b1; #1;
        chk("t6_wait_req", 32'(imem_req), 0);
        cyc(); reset = 1'b0; stray = 1'b1; lat = 1; #1;
        chk("t6_req", 32'(imem_req), 1);
        chk("t6_addr", 32'(imem_addr), 'h00);
        chk("t6_occ", 32'(occupancy), 0);
        cyc(); stray = 1'b0; #1;
        chk("t6_nopush_occ", 32'(occupancy), 0);
        chk("t6_nopush_valid", 32'(valid), 0);
        chk("t6_wait_req2", 32'(imem_req), 0);
        cyc(); #1;
        chk("t6_valid", 32'(valid), 1);
        chk("t6_pc", 32'(PC_out), 'h00);
        chk("t6_instr", 32'(instruction), 'hA000);
        chk("t6_final_occ", 32'(occupancy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
